// File: rtl/encoding_scheduler.sv
// Sequencer for the HD encoding datapath: streams feature chunks into the
// accumulator array, captures the hypervector and hands it out via valid/ready.
module encoding_scheduler #(
    parameter int M_SIZE    = 64,
    parameter int N_SIZE    = 64,
    parameter int FTWIDTH   = 8,
    parameter int DIM_WIDTH = 16,
    parameter int DIV_SIZE  = 512,
    parameter int ENC_LAT   = 1,
    localparam int P        = DIV_SIZE / M_SIZE,
    localparam int AW       = (P > 1) ? $clog2(P) : 1,
    localparam int PBW      = (DIV_SIZE > 1) ? $clog2(DIV_SIZE) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    output logic                        busy,
    output logic                        feat_rd_en,
    output logic [AW-1:0]               feat_addr,
    input  logic [M_SIZE*FTWIDTH-1:0]   feat_rdata,
    output logic [M_SIZE*FTWIDTH-1:0]   enc_features,
    output logic                        enc_en,
    output logic                        enc_clear,
    output logic [PBW-1:0]              proj_base,
    input  logic [M_SIZE*DIM_WIDTH-1:0] enc_result,
    output logic [M_SIZE*DIM_WIDTH-1:0] out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        done
);
    localparam int LW = (ENC_LAT > 0) ? $clog2(ENC_LAT + 1) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FEED  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    if ((DIV_SIZE % M_SIZE) != 0 || ENC_LAT < 1 || N_SIZE < 1) begin : g_bad_params
        $fatal(1, "encoding_scheduler: DIV_SIZE must be a multiple of M_SIZE and ENC_LAT >= 1");
    end

    logic [1:0]                  state_q, state_d;
    logic [AW-1:0]               chunk_q, chunk_d;
    logic [LW-1:0]               drain_q, drain_d;
    logic                        rd_en_q, rd_en_d;
    logic [AW-1:0]               addr_q, addr_d;
    logic                        enc_en_q, enc_en_d;
    logic                        enc_clear_q, enc_clear_d;
    logic [PBW-1:0]              proj_base_q, proj_base_d;
    logic                        out_valid_q, out_valid_d;
    logic [M_SIZE*DIM_WIDTH-1:0] out_data_q, out_data_d;
    logic                        done_q, done_d;

    // FEED walks chunk indices while the read strobe and address follow one
    // cycle behind; the enable/clear/base strobes follow the read by another.
    always_comb begin
        state_d     = state_q;
        chunk_d     = chunk_q;
        drain_d     = drain_q;
        rd_en_d     = 1'b0;
        addr_d      = '0;
        enc_en_d    = rd_en_q;
        enc_clear_d = rd_en_q && (addr_q == '0);
        proj_base_d = PBW'(int'(addr_q) * M_SIZE);
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FEED;
                    chunk_d = '0;
                end
            end
            S_FEED: begin
                rd_en_d = 1'b1;
                addr_d  = chunk_q;
                if (chunk_q == AW'(P - 1)) begin
                    state_d = S_DRAIN;
                    chunk_d = '0;
                    drain_d = '0;
                end else begin
                    chunk_d = chunk_q + AW'(1);
                end
            end
            S_DRAIN: begin
                // Waits out the array latency past the final enable.
                if (drain_q == LW'(ENC_LAT)) begin
                    state_d     = S_OUT;
                    out_valid_d = 1'b1;
                    out_data_d  = enc_result;
                    drain_d     = '0;
                end else begin
                    drain_d = drain_q + LW'(1);
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            chunk_q     <= '0;
            drain_q     <= '0;
            rd_en_q     <= 1'b0;
            addr_q      <= '0;
            enc_en_q    <= 1'b0;
            enc_clear_q <= 1'b0;
            proj_base_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            chunk_q     <= chunk_d;
            drain_q     <= drain_d;
            rd_en_q     <= rd_en_d;
            addr_q      <= addr_d;
            enc_en_q    <= enc_en_d;
            enc_clear_q <= enc_clear_d;
            proj_base_q <= proj_base_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end

    assign busy         = (state_q != S_IDLE);
    assign feat_rd_en   = rd_en_q;
    assign feat_addr    = addr_q;
    assign enc_features = feat_rdata;
    assign enc_en       = enc_en_q;
    assign enc_clear    = enc_clear_q;
    assign proj_base    = proj_base_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign done         = done_q;

endmodule

// File: tb/tb_encoding_scheduler.sv
// Scoreboard bench for encoding_scheduler: a timeline reference model queues
// expected reads, enables, outputs and done pulses; a monitor checks them.
module tb_encoding_scheduler;
    localparam int M   = 64;
    localparam int NS  = 64;
    localparam int FT  = 8;
    localparam int DW  = 16;
    localparam int DIV = 512;
    localparam int LAT = 1;
    localparam int P   = DIV / M;
    localparam int V   = P + 1 + LAT;
    localparam int AW  = $clog2(P);
    localparam int PBW = $clog2(DIV);
    localparam int FW  = M * FT;
    localparam int OW  = M * DW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          out_ready = 1'b0;
    logic          busy, feat_rd_en, enc_en, enc_clear, out_valid, done;
    logic [AW-1:0] feat_addr;
    logic [PBW-1:0] proj_base;
    logic [FW-1:0] feat_rdata, enc_features;
    logic [OW-1:0] enc_result, out_data;

    encoding_scheduler #(
        .M_SIZE(M), .N_SIZE(NS), .FTWIDTH(FT), .DIM_WIDTH(DW),
        .DIV_SIZE(DIV), .ENC_LAT(LAT)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .feat_rd_en(feat_rd_en), .feat_addr(feat_addr), .feat_rdata(feat_rdata),
        .enc_features(enc_features), .enc_en(enc_en), .enc_clear(enc_clear),
        .proj_base(proj_base), .enc_result(enc_result), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .done(done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int edge_n = 0;

    task automatic chk_int(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, edge_n, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        int bad;
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            bad = 0;
            for (int l = M - 1; l >= 0; l--)
                if (act[l*DW +: DW] !== exp[l*DW +: DW]) bad = l;
            $display("FAIL %s cycle %0d lane %0d: got %h expected %h", name, edge_n, bad,
                     act[bad*DW +: DW], exp[bad*DW +: DW]);
        end
    endtask

    task automatic fail_evt(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s cycle %0d: event seen vs expected schedule", name, edge_n);
    endtask

    // Feature memory: synchronous read, junk when not reading.
    logic [FW-1:0] mem [P];
    always @(posedge clk) begin
        logic [FW-1:0] junk;
        for (int w = 0; w < FW / 32; w++) junk[w*32 +: 32] = $urandom;
        feat_rdata <= feat_rd_en ? mem[feat_addr] : junk;
    end

    // Accumulator array: result reflects the chunk presented this cycle.
    logic [OW-1:0] acc = '0;
    always_comb begin
        enc_result = acc;
        if (enc_en)
            for (int l = 0; l < M; l++)
                enc_result[l*DW +: DW] = (enc_clear ? {DW{1'b0}} : acc[l*DW +: DW])
                                         + DW'(enc_features[l*FT +: FT]);
    end
    always @(posedge clk) if (enc_en) acc <= enc_result;

    function automatic logic [OW-1:0] exp_sum();
        logic [OW-1:0] s;
        s = '0;
        for (int l = 0; l < M; l++) begin
            int t;
            t = 0;
            for (int c = 0; c < P; c++) t += int'(mem[c][l*FT +: FT]);
            s[l*DW +: DW] = DW'(t);
        end
        return s;
    endfunction

    typedef struct { int cyc; int addr; } rd_exp_t;
    typedef struct { int cyc; logic clr; int pb; } enc_exp_t;
    typedef struct { int cyc; logic [OW-1:0] data; } out_exp_t;
    rd_exp_t  rd_q[$];
    enc_exp_t enc_q[$];
    out_exp_t out_q[$];
    int       done_q[$];

    bit m_active = 0;
    bit m_valid_seen = 0;
    int m_t0 = 0;
    int m_accepts = 0;

    // Reference timeline: one sample in flight; cycle numbers are edge indices.
    always @(posedge clk) begin
        edge_n++;
        if (reset) begin
            if (m_active) begin
                if (m_valid_seen && out_ready) begin
                    m_active = 0;
                    m_valid_seen = 0;
                    done_q.push_back(edge_n);
                end else if (edge_n == m_t0 + V) begin
                    m_valid_seen = 1;
                end
            end else if (start) begin
                m_active = 1;
                m_valid_seen = 0;
                m_t0 = edge_n;
                m_accepts++;
                for (int i = 0; i < P; i++) begin
                    rd_q.push_back('{cyc: edge_n + 1 + i, addr: i});
                    enc_q.push_back('{cyc: edge_n + 2 + i, clr: (i == 0), pb: i * M});
                end
                out_q.push_back('{cyc: edge_n + V, data: exp_sum()});
            end
        end
    end

    always @(negedge reset) begin
        m_active = 0;
        m_valid_seen = 0;
        rd_q.delete();
        enc_q.delete();
        out_q.delete();
        done_q.delete();
    end

    bit seen_valid = 0;
    always @(negedge clk) begin
        if (!reset) begin
            chk_int("rst_ctrl", 64'({busy, feat_rd_en, enc_en, enc_clear, out_valid, done}), 64'(0));
            chk_int("rst_addr", 64'(feat_addr), 64'(0));
            chk_int("rst_pbase", 64'(proj_base), 64'(0));
            chk_vec("rst_data", out_data, '0);
            seen_valid = 0;
        end else begin
            chk_int("busy", 64'(busy), 64'(m_active));
            if (!m_active) begin
                chk_int("idle_addr", 64'(feat_addr), 64'(0));
                chk_int("idle_pbase", 64'(proj_base), 64'(0));
            end
            if (feat_rd_en) begin
                if (rd_q.size() == 0) fail_evt("rd_unexpected");
                else begin
                    rd_exp_t r;
                    r = rd_q.pop_front();
                    chk_int("rd_cycle", 64'(edge_n), 64'(r.cyc));
                    chk_int("rd_addr", 64'(feat_addr), 64'(r.addr));
                end
            end else if (rd_q.size() != 0 && rd_q[0].cyc <= edge_n) begin
                fail_evt("rd_missing");
                void'(rd_q.pop_front());
            end
            if (enc_en) begin
                if (enc_q.size() == 0) fail_evt("enc_unexpected");
                else begin
                    enc_exp_t e;
                    e = enc_q.pop_front();
                    chk_int("enc_cycle", 64'(edge_n), 64'(e.cyc));
                    chk_int("enc_clear", 64'(enc_clear), 64'(e.clr));
                    chk_int("proj_base", 64'(proj_base), 64'(e.pb));
                end
            end else begin
                chk_int("clear_without_en", 64'(enc_clear), 64'(0));
                if (enc_q.size() != 0 && enc_q[0].cyc <= edge_n) begin
                    fail_evt("enc_missing");
                    void'(enc_q.pop_front());
                end
            end
            if (out_valid) begin
                if (out_q.size() == 0) fail_evt("valid_unexpected");
                else begin
                    if (!seen_valid) chk_int("valid_cycle", 64'(edge_n), 64'(out_q[0].cyc));
                    seen_valid = 1;
                    chk_vec("out_data", out_data, out_q[0].data);
                    if (out_ready) begin
                        void'(out_q.pop_front());
                        seen_valid = 0;
                    end
                end
            end else if (out_q.size() != 0 && out_q[0].cyc <= edge_n) begin
                fail_evt("valid_missing");
                void'(out_q.pop_front());
            end
            if (done) begin
                if (done_q.size() == 0) fail_evt("done_unexpected");
                else chk_int("done_cycle", 64'(edge_n), 64'(done_q.pop_front()));
            end else if (done_q.size() != 0 && done_q[0] <= edge_n) begin
                fail_evt("done_missing");
                void'(done_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max_cyc);
        for (int i = 0; i < max_cyc && m_active; i++) tick();
        chk_int("idle_timeout", 64'(m_active), 64'(0));
    endtask

    task automatic mem_pattern();
        for (int c = 0; c < P; c++)
            for (int l = 0; l < M; l++) mem[c][l*FT +: FT] = FT'(c);
    endtask

    task automatic mem_random();
        for (int c = 0; c < P; c++)
            for (int w = 0; w < FW / 32; w++) mem[c][w*32 +: 32] = $urandom;
    endtask

    logic [OW-1:0] all28;
    int base;

    initial begin
        for (int l = 0; l < M; l++) all28[l*DW +: DW] = DW'(28);
        mem_pattern();
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk_vec("idle_out_data", out_data, '0);
        end

        // Single sample, consumer always ready.
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(40);
        chk_vec("lane_sum_28", out_data, all28);

        // Backpressure: hold off the consumer five cycles after valid rises.
        out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 40 && !m_valid_seen; i++) tick();
        chk_int("valid_timeout", 64'(m_valid_seen), 64'(1));
        repeat (5) tick();
        out_ready = 1'b1;
        wait_idle(20);

        // Back-to-back with start held across done.
        base = m_accepts;
        start = 1'b1;
        for (int i = 0; i < 80 && m_accepts < base + 2; i++) tick();
        start = 1'b0;
        chk_int("b2b_timeout", 64'(m_accepts - base), 64'(2));
        wait_idle(40);
        chk_vec("lane_sum_28_again", out_data, all28);

        // Starts during a sample are ignored, including on the handshake edge.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (15) tick();

        // Abort mid-feed, then a clean sample.
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_idle(40);
        chk_vec("lane_sum_after_abort", out_data, all28);

        // Randomized traffic with random memory contents.
        mem_random();
        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 1) == 1);
            tick();
        end
        start = 1'b0;
        out_ready = 1'b1;
        wait_idle(60);
        repeat (3) tick();
        chk_int("queues_drained", 64'(rd_q.size() + enc_q.size() + out_q.size() + done_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/encoding_scheduler.md
Name: encoding_scheduler

Overview:
- Sequencing controller for the HD encoding datapath.
- On each start it streams DIV_SIZE/M_SIZE feature chunks from a synchronous feature memory into the M_SIZE-lane accumulator array. With each chunk it issues the matching projection base offset and the clear/enable strobes.
- After the last chunk it captures the accumulated hypervector and presents it through a valid/ready output, then pulses done.
- Sits between the feature buffer/host and the encoder array. It replaces the free-running count/done logic inside the encoder.

Parameters:
- M_SIZE, 64, accumulator lanes = features per chunk
- N_SIZE, 64, projection window width per lane
- FTWIDTH, 8, bits per feature
- DIM_WIDTH, 16, accumulator result width per lane
- DIV_SIZE, 512, total features per sample; must be a multiple of M_SIZE
- ENC_LAT, 1, cycles from the last enc_en to a stable enc_result (≥1)

Ports:
- clk  in  1  clock; all state changes on posedge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  request to encode one sample; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- feat_rd_en  out  1  feature memory read strobe
- feat_addr  out  $clog2(DIV_SIZE/M_SIZE)  chunk index being read
- feat_rdata  in  M_SIZE*FTWIDTH  memory data, valid the cycle after feat_rd_en
- enc_features  out  M_SIZE*FTWIDTH  feature chunk to the array; combinational pass-through of feat_rdata
- enc_en  out  1  array accumulates enc_features this cycle
- enc_clear  out  1  first chunk; array replaces its sum instead of adding (asserted only together with enc_en)
- proj_base  out  $clog2(DIV_SIZE)  projection offset = chunk*M_SIZE, aligned with enc_en
- enc_result  in  M_SIZE*DIM_WIDTH  accumulator array outputs
- out_data  out  M_SIZE*DIM_WIDTH  captured hypervector; holds until the next capture
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- done  out  1  one-cycle pulse after the output handshake completes

Behaviour:
- Reset (reset=0, async): state=IDLE; all of busy, feat_rd_en, feat_addr, enc_en, enc_clear, proj_base, out_valid, done = 0; out_data = 0; chunk and drain counters = 0. Outputs stay at these values while reset is low.
- Reset mid-operation aborts immediately. No partial output and no done pulse are produced.
- P = DIV_SIZE/M_SIZE (default 8). Edge E0 is the edge where start=1 is sampled in IDLE; "cycle k" is the cycle after edge Ek.
- IDLE: busy=0. start=1 → FEED. start while busy is ignored; it is neither queued nor an error.
- FEED: feat_rd_en=1 for exactly P cycles (cycles 1..P), with feat_addr = 0..P-1 in order. After the cycle with feat_addr=P-1 → DRAIN.
- Enable pipeline: enc_en is feat_rd_en registered one cycle, so it is high in cycles 2..P+1. proj_base is feat_addr*M_SIZE registered the same way. enc_clear=1 only in cycle 2 (chunk 0).
- No bubbles: enc_en is never deasserted between chunks of one sample.
- DRAIN: starts with the cycle after the last read, which is also the last enc_en cycle. The drain counter runs ENC_LAT cycles past the last enc_en. out_data <= enc_result at edge E(P+1+ENC_LAT); out_valid=1 from cycle P+1+ENC_LAT → OUT.
- Default latency: out_valid first high in cycle 10.
- OUT: out_valid and out_data are held stable until out_valid & out_ready at an edge.
  - If out_ready is already high when out_valid rises, the handshake completes at the first edge.
  - At the handshake edge: out_valid→0, done→1 for one cycle, state→IDLE.
- A start sampled in the done cycle (state is IDLE) is accepted. The next sample's FEED then overlaps no prior output.
- out_ready while out_valid=0 is ignored.
- proj_base arithmetic is unsigned. The maximum value (P-1)*M_SIZE fits its width without wrap.
- feat_addr never exceeds P-1. The chunk counter clears on entry to FEED.
- Elaboration check: DIV_SIZE % M_SIZE != 0 or ENC_LAT < 1 → fatal.

Test Plan:
- Reset then idle: hold reset=0 for 3 cycles, release, start=0 for 10 cycles → all outputs 0, busy=0 throughout.
- Single sample, defaults, out_ready=1:
  - feat_rd_en cycles 1..8 with addr 0..7.
  - enc_en cycles 2..9; enc_clear only in cycle 2.
  - proj_base 0,64,…,448.
  - out_valid in cycle 10; done in cycle 11.
- Backpressure: out_ready=0 for 5 cycles after out_valid rises, then 1 → out_data stable all 5 cycles; done exactly one cycle after the accepting edge.
- Memory model returning chunk index as every feature byte, and a model array summing per lane → out_data lanes = 0+1+…+7 = 28. A second back-to-back sample with start held high across done starts FEED in the done cycle and again yields 28, proving enc_clear.
- Start ignored: pulse start in cycles 3 and 10 during a sample → one output only, addr sequence unchanged.
- Abort: assert reset in cycle 5, release at cycle 7 → outputs 0 immediately; no out_valid or done; a fresh start then completes normally with correct timing.
